// File: rtl/tartaruga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tartaruga_pkg : shared types for the tartaruga pipeline back end      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package tartaruga_pkg;

  localparam int CNT_W = 64;

  typedef logic [31:0] bus32_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_origin_e;

  typedef struct packed {
    bus32_t     pc;
    reg_addr_t  rd;
    logic       reg_we;
    wb_origin_e wb_origin;
  } instr_t;

  typedef struct packed {
    logic   valid;
    instr_t instr;
    bus32_t result;
    logic   branch_taken;
    bus32_t branched_pc;
  } mem_to_wb_t;

  typedef struct packed {
    logic      valid;
    bus32_t    pc;
    reg_addr_t rd;
    bus32_t    data;
  } commit_t;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_stage_if : memory-stage bundle, decode reads, redirect and trace   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface wb_stage_if
  import tartaruga_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);

  mem_to_wb_t       mem_to_wb_i;
  reg_addr_t        rs1_addr_i;
  reg_addr_t        rs2_addr_i;
  logic [XLEN-1:0]  rs1_data_o;
  logic [XLEN-1:0]  rs2_data_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             commit_valid_o;
  logic [XLEN-1:0]  commit_pc_o;
  reg_addr_t        commit_rd_o;
  logic [XLEN-1:0]  commit_data_o;
  logic [CNT_W-1:0] cycle_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    output mem_to_wb_i, rs1_addr_i, rs2_addr_i,
    input  rs1_data_o, rs2_data_o, redirect_valid_o, redirect_pc_o,
    input  commit_valid_o, commit_pc_o, commit_rd_o, commit_data_o,
    input  cycle_o, instret_o
  );

  modport slave (
    input  mem_to_wb_i, rs1_addr_i, rs2_addr_i,
    output rs1_data_o, rs2_data_o, redirect_valid_o, redirect_pc_o,
    output commit_valid_o, commit_pc_o, commit_rd_o, commit_data_o,
    output cycle_o, instret_o
  );

endinterface
`default_nettype wire

// File: rtl/wb_stage_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_stage_regfile : 1W/2R register file, write bypass, x0 hardwired    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_stage_regfile
  import tartaruga_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_a_i,
  input  logic [AW-1:0]   raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [AW-1:0]   raddr  [2];

  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0] rdata;
    always_comb begin
      rdata = '0;
      if (raddr[p] != '0) begin
        rdata = (we_i && (waddr_i == raddr[p])) ? wdata_i : regs_q[raddr[p]];
      end
    end
  end

  assign rdata_a_o = g_rd[0].rdata;
  assign rdata_b_o = g_rd[1].rdata;

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_stage : writeback - register file, redirect, commit trace, counters|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module wb_stage
  import tartaruga_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 64
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wb_stage_if.slave wb_if
);

  mem_to_wb_t m;
  logic       ret;
  logic       wr;
  logic       unused_origin;

  assign m             = wb_if.mem_to_wb_i;
  assign ret           = m.valid;
  assign wr            = ret & m.instr.reg_we & (m.instr.rd != '0);
  assign unused_origin = ^m.instr.wb_origin;

  wb_stage_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (wr),
    .waddr_i   (m.instr.rd),
    .wdata_i   (m.result),
    .raddr_a_i (wb_if.rs1_addr_i),
    .raddr_b_i (wb_if.rs2_addr_i),
    .rdata_a_o (wb_if.rs1_data_o),
    .rdata_b_o (wb_if.rs2_data_o)
  );

  logic             redirect_valid_q, redirect_valid_d;
  bus32_t           redirect_pc_q,    redirect_pc_d;
  commit_t          commit_q,         commit_d;
  logic [CNT_W-1:0] cycle_q,          cycle_d;
  logic [CNT_W-1:0] instret_q,        instret_d;

  always_comb begin
    redirect_valid_d = ret & m.branch_taken;
    redirect_pc_d    = redirect_pc_q;
    commit_d         = commit_q;
    commit_d.valid   = ret;
    cycle_d          = cycle_q + CNT_W'(1);
    instret_d        = instret_q;

    if (redirect_valid_d) begin
      redirect_pc_d = m.branched_pc;
    end
    // Trace fields only move on a retire so they keep the last commit visible.
    if (ret) begin
      commit_d.pc   = m.instr.pc;
      commit_d.rd   = wr ? m.instr.rd : '0;
      commit_d.data = wr ? m.result   : '0;
      instret_d     = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      commit_q         <= '0;
      cycle_q          <= '0;
      instret_q        <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      commit_q         <= commit_d;
      cycle_q          <= cycle_d;
      instret_q        <= instret_d;
    end
  end

  assign wb_if.redirect_valid_o = redirect_valid_q;
  assign wb_if.redirect_pc_o    = redirect_pc_q;
  assign wb_if.commit_valid_o   = commit_q.valid;
  assign wb_if.commit_pc_o      = commit_q.pc;
  assign wb_if.commit_rd_o      = commit_q.rd;
  assign wb_if.commit_data_o    = commit_q.data;
  assign wb_if.cycle_o          = cycle_q;
  assign wb_if.instret_o        = instret_q;

endmodule
`default_nettype wire
